// File: rtl/seq_slice_comparator.sv
// Slice-serial unsigned magnitude comparator, LS slice first.
// Registered gt/lt/eq cascade seeded from gti/lti/eqi.
module seq_slice_comparator #(
  parameter int SLICE_W    = 6,
  parameter int NUM_SLICES = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               gti,
  input  logic               lti,
  input  logic               eqi,
  input  logic [SLICE_W-1:0] a_slice,
  input  logic [SLICE_W-1:0] b_slice,
  input  logic               slice_valid,
  output logic               slice_ready,
  input  logic               abort,
  output logic               busy,
  output logic               done,
  output logic               result_valid,
  output logic               gto,
  output logic               lto,
  output logic               eqo
);

  localparam int CW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_SLICES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        r_state, w_state;
  logic [CW-1:0] r_cnt, w_cnt;
  logic          r_gt, r_lt, r_eq;
  logic          w_gt, w_lt, w_eq;
  logic          r_ready, w_ready;
  logic          r_busy, w_busy;
  logic          r_done, w_done;
  logic          r_rv, w_rv;
  logic          w_hs;
  logic          w_a_gt, w_a_lt;

  assign w_hs   = slice_valid & r_ready;
  assign w_a_gt = a_slice > b_slice;
  assign w_a_lt = a_slice < b_slice;

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_gt    = r_gt;
    w_lt    = r_lt;
    w_eq    = r_eq;
    w_ready = r_ready;
    w_busy  = r_busy;
    w_done  = 1'b0;
    w_rv    = r_rv;
    unique case (r_state)
      IDLE, DONE: begin
        if (start) begin
          w_state = RUN;
          w_cnt   = '0;
          w_rv    = 1'b0;
          w_busy  = 1'b1;
          w_ready = 1'b1;
          // eq seed dominates, then gt, then lt
          w_eq = eqi | ~(gti | lti);
          w_gt = ~eqi & gti;
          w_lt = ~eqi & ~gti & lti;
        end
      end
      RUN: begin
        if (w_hs) begin
          if (w_a_gt) begin
            w_gt = 1'b1;
            w_lt = 1'b0;
            w_eq = 1'b0;
          end else if (w_a_lt) begin
            w_gt = 1'b0;
            w_lt = 1'b1;
            w_eq = 1'b0;
          end
          if (r_cnt == LAST) begin
            w_state = DONE;
            w_cnt   = '0;
            w_ready = 1'b0;
            w_busy  = 1'b0;
            w_done  = 1'b1;
            w_rv    = 1'b1;
          end else begin
            w_cnt = r_cnt + 1'b1;
          end
        end
      end
      default: w_state = IDLE;
    endcase
    if (abort) begin
      w_state = IDLE;
      w_cnt   = '0;
      w_gt    = 1'b0;
      w_lt    = 1'b0;
      w_eq    = 1'b1;
      w_ready = 1'b0;
      w_busy  = 1'b0;
      w_done  = 1'b0;
      w_rv    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_gt    <= 1'b0;
      r_lt    <= 1'b0;
      r_eq    <= 1'b1;
      r_ready <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_rv    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_gt    <= w_gt;
      r_lt    <= w_lt;
      r_eq    <= w_eq;
      r_ready <= w_ready;
      r_busy  <= w_busy;
      r_done  <= w_done;
      r_rv    <= w_rv;
    end
  end

  assign slice_ready  = r_ready;
  assign busy         = r_busy;
  assign done         = r_done;
  assign result_valid = r_rv;
  assign gto          = r_gt;
  assign lto          = r_lt;
  assign eqo          = r_eq;

endmodule

// File: tb/tb_seq_slice_comparator.sv
// Directed bench for seq_slice_comparator (2-slice and 1-slice builds).
// Vector table plus hand sequences for stall, reset, abort, back-to-back.
module tb_seq_slice_comparator;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, gti, lti, eqi;
  logic [5:0] a_slice, b_slice;
  logic       slice_valid, abort;
  logic       slice_ready, busy, done, result_valid, gto, lto, eqo;
  logic       ready1, busy1, done1, rv1, gto1, lto1, eqo1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  seq_slice_comparator #(.SLICE_W(6), .NUM_SLICES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .gti(gti), .lti(lti), .eqi(eqi),
    .a_slice(a_slice), .b_slice(b_slice),
    .slice_valid(slice_valid), .slice_ready(slice_ready),
    .abort(abort), .busy(busy), .done(done),
    .result_valid(result_valid),
    .gto(gto), .lto(lto), .eqo(eqo)
  );

  seq_slice_comparator #(.SLICE_W(6), .NUM_SLICES(1)) u_one (
    .clk(clk), .rst_n(rst_n), .start(start),
    .gti(gti), .lti(lti), .eqi(eqi),
    .a_slice(a_slice), .b_slice(b_slice),
    .slice_valid(slice_valid), .slice_ready(ready1),
    .abort(abort), .busy(busy1), .done(done1),
    .result_valid(rv1),
    .gto(gto1), .lto(lto1), .eqo(eqo1)
  );

  typedef struct {
    logic       gi, li, ei;
    logic [5:0] alo, blo, ahi, bhi;
    int         stall;
    logic       xg, xl, xe;
  } vec_t;

  task automatic chk(input string nm, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_res(input string nm, input logic g,
                         input logic l, input logic e);
    chk({nm, ".gto"}, int'(gto), int'(g));
    chk({nm, ".lto"}, int'(lto), int'(l));
    chk({nm, ".eqo"}, int'(eqo), int'(e));
  endtask

  task automatic do_start(input logic g, input logic l, input logic e);
    gti = g; lti = l; eqi = e; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [5:0] a, input logic [5:0] b);
    a_slice = a; b_slice = b; slice_valid = 1'b1;
    @(negedge clk);
    slice_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string s;
    s = $sformatf("vec%0d", idx);
    do_start(v.gi, v.li, v.ei);
    chk({s, ".busy"}, int'(busy), 1);
    chk({s, ".ready"}, int'(slice_ready), 1);
    chk({s, ".rv_clr"}, int'(result_valid), 0);
    send(v.alo, v.blo);
    chk({s, ".nodone0"}, int'(done), 0);
    for (int k = 0; k < v.stall; k++) begin
      @(negedge clk);
      chk({s, ".stall_rdy"}, int'(slice_ready), 1);
      chk({s, ".stall_busy"}, int'(busy), 1);
      chk({s, ".stall_done"}, int'(done), 0);
    end
    send(v.ahi, v.bhi);
    chk({s, ".done"}, int'(done), 1);
    chk({s, ".rv"}, int'(result_valid), 1);
    chk({s, ".busy_lo"}, int'(busy), 0);
    chk({s, ".ready_lo"}, int'(slice_ready), 0);
    chk_res(s, v.xg, v.xl, v.xe);
    @(negedge clk);
    chk({s, ".done_fall"}, int'(done), 0);
    chk({s, ".rv_hold"}, int'(result_valid), 1);
    chk_res({s, "_hold"}, v.xg, v.xl, v.xe);
  endtask

  vec_t vt[8];

  initial begin
    vt[0] = '{1'b0, 1'b0, 1'b1, 6'd10, 6'd20, 6'd45, 6'd57, 0, 1'b0, 1'b1, 1'b0};
    vt[1] = '{1'b0, 1'b0, 1'b1, 6'd50, 6'd7, 6'd33, 6'd33, 0, 1'b1, 1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b0, 1'b0, 6'd12, 6'd12, 6'd63, 6'd63, 0, 1'b1, 1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b0, 1'b1, 6'd12, 6'd12, 6'd63, 6'd63, 0, 1'b0, 1'b0, 1'b1};
    vt[4] = '{1'b0, 1'b1, 1'b0, 6'd0, 6'd0, 6'd0, 6'd0, 0, 1'b0, 1'b1, 1'b0};
    vt[5] = '{1'b0, 1'b0, 1'b0, 6'd63, 6'd0, 6'd0, 6'd63, 0, 1'b0, 1'b1, 1'b0};
    vt[6] = '{1'b0, 1'b0, 1'b1, 6'd5, 6'd9, 6'd40, 6'd39, 0, 1'b1, 1'b0, 1'b0};
    vt[7] = '{1'b0, 1'b0, 1'b1, 6'd10, 6'd20, 6'd45, 6'd57, 3, 1'b0, 1'b1, 1'b0};

    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    gti = 1'b0; lti = 1'b0; eqi = 1'b0;
    a_slice = '0; b_slice = '0; slice_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst.busy", int'(busy), 0);
    chk("rst.ready", int'(slice_ready), 0);
    chk("rst.done", int'(done), 0);
    chk("rst.rv", int'(result_valid), 0);
    chk_res("rst", 1'b0, 1'b0, 1'b1);
    rst_n = 1'b1;

    slice_valid = 1'b1;
    @(negedge clk);
    slice_valid = 1'b0;
    chk("idle_valid.ready", int'(slice_ready), 0);
    chk("idle_valid.busy", int'(busy), 0);

    for (int i = 0; i < 8; i++) run_vec(vt[i], i);

    // start pulsed mid-run is ignored, then async reset
    do_start(1'b0, 1'b0, 1'b1);
    send(6'd10, 6'd20);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("midstart.busy", int'(busy), 1);
    chk("midstart.rv", int'(result_valid), 0);
    chk_res("midstart", 1'b0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.busy", int'(busy), 0);
    chk("arst.rv", int'(result_valid), 0);
    chk_res("arst", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vt[1], 100);

    // abort beats a same-cycle handshake
    do_start(1'b0, 1'b0, 1'b1);
    send(6'd50, 6'd7);
    abort = 1'b1;
    send(6'd1, 6'd60);
    abort = 1'b0;
    chk("abort.busy", int'(busy), 0);
    chk("abort.ready", int'(slice_ready), 0);
    chk("abort.rv", int'(result_valid), 0);
    chk("abort.done", int'(done), 0);
    chk_res("abort", 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    chk("abort.done2", int'(done), 0);

    // start held over last handshake into done cycle: restart from DONE
    do_start(1'b0, 1'b0, 1'b1);
    send(6'd1, 6'd2);
    start = 1'b1;
    send(6'd3, 6'd2);
    chk("b2b.done", int'(done), 1);
    chk_res("b2b.first", 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b.busy", int'(busy), 1);
    chk("b2b.rv_clr", int'(result_valid), 0);
    chk("b2b.done_lo", int'(done), 0);
    chk_res("b2b.seed", 1'b0, 1'b0, 1'b1);
    send(6'd7, 6'd7);
    send(6'd7, 6'd7);
    chk("b2b2.done", int'(done), 1);
    chk_res("b2b2", 1'b0, 1'b0, 1'b1);
    @(negedge clk);

    // single-slice build: result two edges after start
    do_start(1'b0, 1'b0, 1'b1);
    chk("one.busy", int'(busy1), 1);
    send(6'd45, 6'd57);
    chk("one.done", int'(done1), 1);
    chk("one.rv", int'(rv1), 1);
    chk("one.lto", int'(lto1), 1);
    chk("one.gto", int'(gto1), 0);
    chk("one.eqo", int'(eqo1), 0);
    chk("one.ready", int'(ready1), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_slice_comparator.md
Name: seq_slice_comparator

Overview:
- Sequential magnitude comparator for wide operands (SLICE_W*NUM_SLICES bits).
- Operands arrive one slice per handshake, least-significant slice first.
- The block runs the gt/lt/eq cascade chain as a register. It is the producing end of the cascade: its seed inputs come in as gti/lti/eqi, and its gto/lto/eqo results drive downstream ripple comparators or control logic.
- Sits between a slice-serial operand source (memory or shift path) and the comparator chain.

Parameters:
- SLICE_W, 6, width of each operand slice in bits.
- NUM_SLICES, 4, number of slices per comparison; minimum 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin new comparison; sampled only in IDLE or DONE.
- gti  input  1  cascade seed "greater" from lower-order logic.
- lti  input  1  cascade seed "less".
- eqi  input  1  cascade seed "equal".
- a_slice  input  SLICE_W  operand A slice, unsigned.
- b_slice  input  SLICE_W  operand B slice, unsigned.
- slice_valid  input  1  a_slice/b_slice valid.
- slice_ready  output  1  block accepts a slice this cycle.
- abort  input  1  cancel the comparison in progress.
- busy  output  1  high in RUN.
- done  output  1  one-cycle pulse when the result becomes valid.
- result_valid  output  1  gto/lto/eqo hold a final result.
- gto  output  1  A > B.
- lto  output  1  A < B.
- eqo  output  1  A == B.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, gto=0, lto=0, eqo=1, slice_ready=0, busy=0, done=0, result_valid=0, slice counter=0. Reset mid-comparison discards all progress.
- States: IDLE, RUN, DONE. All outputs are registered.
- IDLE/DONE with start=1: at the clock edge, load the cascade register from the seed and go to RUN. Also clear result_valid, clear the counter, and set busy=1 and slice_ready=1.
- Seed priority: eqi=1 gives EQ (regardless of gti/lti); else gti=1 gives GT; else lti=1 gives LT; else EQ.
- RUN: slice_ready=1 continuously. A slice is accepted on any edge with slice_valid & slice_ready.
- Per accepted slice, unsigned compare:
  - a_slice > b_slice sets GT.
  - a_slice < b_slice sets LT.
  - equal keeps the current state.
  - This works because later slices are more significant and override earlier ones.
- Exactly one of gto/lto/eqo is high at all times.
- gto/lto/eqo reflect the running state during RUN, but are meaningful only when result_valid=1.
- Counter increments per accepted slice. The edge accepting slice NUM_SLICES moves to DONE, with slice_ready=0, busy=0, done=1 and result_valid=1 all visible the cycle after the last handshake.
- done falls after one cycle. result_valid and gto/lto/eqo hold until the next accepted start, abort, or reset.
- slice_valid low in RUN: stall, with no state change and no timeout.
- start during RUN: ignored.
- slice_valid outside RUN: ignored (slice_ready=0).
- abort (any state, synchronous):
  - Next edge: state=IDLE, outputs to reset values, counter=0.
  - abort has priority over start and over a same-cycle handshake.
- start and a last-slice handshake in the same cycle: start is ignored (in RUN). start is accepted in DONE the following cycle or later.
- Back-to-back: start asserted in the done cycle is accepted, so a new RUN begins on the next edge.
- Throughput: one slice per cycle. Minimum comparison time is NUM_SLICES+1 cycles from start.

Test Plan (SLICE_W=6, NUM_SLICES=2 unless noted):
- Seed eqi=1; start; slices lo A=10,B=20 then hi A=45,B=57 on consecutive cycles -> done pulse 1 cycle after second handshake; lto=1, gto=0, eqo=0, result_valid=1 held.
- Seed eqi=1; slices lo A=50,B=7, hi A=33,B=33 -> gto=1, lto=0, eqo=0 (equal high slice keeps low-slice result).
- Seed gti=1, lti=0, eqi=0; slices lo 12/12, hi 63/63 -> gto=1. Repeat with gti=1, eqi=1 -> eqo=1 (seed priority).
- Stall: slice_valid low 3 cycles between slices -> slice_ready stays 1, busy=1, no done; result is the same as the unstalled case.
- Mid-run: after first slice, pulse start -> ignored. Then assert rst_n=0 asynchronously -> outputs immediately gto=0, lto=0, eqo=1, busy=0, result_valid=0. After release, a fresh run completes correctly.
- Abort after first slice, concurrent with slice_valid=1 -> next cycle IDLE, result_valid=0, no done. Then NUM_SLICES=1 build: A=45,B=57 single slice -> lto=1 two cycles after start.
